uart_tx_frame: RTL

Parametrised UART transmit engine. It replaces the combinational start/data/parity/stop output selector with a complete framing block. The block accepts a parallel word through a valid/ready handshake and serialises it as one frame: start bit, DATA_BITS data bits LSB first, an optional parity bit, then 1 or 2 stop bits. It keeps its own bit-period counter, so it connects directly between the core's TX request logic and the tx pin.

---
 rtl/uart_tx_frame_if.sv | 30 +++
 rtl/uart_tx_frame.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// Handshake and serial-line bundle for the UART transmit framer.
// The master drives the word; the slave (framer) drives the line and status.
interface uart_tx_frame_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic                 tx_out;
   logic                 busy;
   logic                 tx_done;

   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready,
      input  tx_out,
      input  busy,
      input  tx_done
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready,
      output tx_out,
      output busy,
      output tx_done
   );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Owns its bit-period counter; tx_out is registered and idles high.
module uart_tx_frame #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input logic             clk,
   input logic             reset,
   uart_tx_frame_if.slave  bus
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
   localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
   localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);
   localparam logic ParityEn  = (PARITY_EN != 0);
   localparam logic ParityOdd = (PARITY_ODD != 0);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
   end
   if (PARITY_EN > 1 || PARITY_ODD > 1) begin : g_bad_parity
      $error("uart_tx_frame: PARITY_EN and PARITY_ODD must be 0 or 1");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if ($bits(bus.tx_data) != DATA_BITS) begin : g_bad_if_width
      $error("uart_tx_frame: interface data width does not match DATA_BITS");
   end

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_out_q, tx_out_d;
   logic                 cnt_last;

   assign cnt_last = (cnt_q == CntMax);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_out_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_out_q <= tx_out_d;
      end
   end

   // tx_out_d is the level of the bit that the next state will be sending,
   // so the line changes on the same edge as the state.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tx_out_d = tx_out_q;

      if (state_q != StIdle) begin
         cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            tx_out_d = 1'b1;
            if (bus.tx_valid) begin
               state_d  = StStart;
               tx_out_d = 1'b0;
               cnt_d    = '0;
               bit_d    = '0;
               shift_d  = bus.tx_data;
               par_d    = (^bus.tx_data) ^ ParityOdd;
            end
         end
         StStart: begin
            if (cnt_last) begin
               state_d  = StData;
               bit_d    = '0;
               tx_out_d = shift_q[0];
               shift_d  = shift_q >> 1;
            end
         end
         StData: begin
            if (cnt_last) begin
               if (bit_q == DataLast) begin
                  bit_d = '0;
                  if (ParityEn) begin
                     state_d  = StParity;
                     tx_out_d = par_q;
                  end else begin
                     state_d  = StStop;
                     tx_out_d = 1'b1;
                  end
               end else begin
                  bit_d    = bit_q + 4'd1;
                  tx_out_d = shift_q[0];
                  shift_d  = shift_q >> 1;
               end
            end
         end
         StParity: begin
            if (cnt_last) begin
               state_d  = StStop;
               bit_d    = '0;
               tx_out_d = 1'b1;
            end
         end
         StStop: begin
            tx_out_d = 1'b1;
            if (cnt_last) begin
               if (bit_q == StopLast) begin
                  state_d = StIdle;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            cnt_d    = '0;
            bit_d    = '0;
            tx_out_d = 1'b1;
         end
      endcase
   end

   assign bus.tx_ready = (state_q == StIdle);
   assign bus.busy     = (state_q != StIdle);
   assign bus.tx_out   = tx_out_q;
   assign bus.tx_done  = (state_q == StStop) && cnt_last && (bit_q == StopLast);

endmodule
